// File: rtl/axis_write_addr.sv
// axis_write_addr: command/address stage for the AXI write path.
// Accepts one write command (start byte address, length in stream words),
// forwards the length to axis_write_data, and splits the command into
// maximum-size INCR bursts on AW. It counts the bursts in flight, consumes B,
// and pulses done when the last response has come back.
// Optional feature macro: AXIS_WRITE_ADDR_BRESP_EN. When it is defined, a
// SLVERR/DECERR response sets a sticky err flag. When it is undefined,
// axi_bresp is ignored and err is tied low.
module axis_write_addr #(
  parameter int CFG_DWIDTH     = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int CONVERT_SHIFT  = 1,
  parameter int OUT_AWIDTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CFG_DWIDTH-1:0]     cfg_address,
  input  logic [CFG_DWIDTH-1:0]     cfg_length,
  input  logic                      cfg_val,
  output logic                      cfg_rdy,
  output logic [CFG_DWIDTH-1:0]     data_cfg_length,
  output logic                      data_cfg_val,
  input  logic                      data_cfg_rdy,
  output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
  output logic [AXI_LEN_WIDTH-1:0]  axi_awlen,
  output logic [2:0]                axi_awsize,
  output logic [1:0]                axi_awburst,
  output logic                      axi_awvalid,
  input  logic                      axi_awready,
  input  logic [1:0]                axi_bresp,
  input  logic                      axi_bvalid,
  output logic                      axi_bready,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  // Bytes per AXI beat, expressed as a shift amount.
  localparam int BYTE_SHIFT = $clog2(AXI_DATA_WIDTH / 8);

  localparam logic [CFG_DWIDTH-1:0] CFG_ZERO  = {CFG_DWIDTH{1'b0}};
  localparam logic [CFG_DWIDTH-1:0] CFG_ONE   = {{(CFG_DWIDTH-1){1'b0}}, 1'b1};
  // Largest burst in beats. This is one more than the largest awlen.
  localparam logic [CFG_DWIDTH-1:0] MAX_BURST = CFG_ONE << AXI_LEN_WIDTH;
  // Added before the shift so that a partial AXI beat rounds up.
  localparam logic [CFG_DWIDTH-1:0] ROUND_ADD = (CFG_ONE << CONVERT_SHIFT) - CFG_ONE;

  localparam logic [OUT_AWIDTH-1:0] OUT_ZERO  = {OUT_AWIDTH{1'b0}};
  localparam logic [OUT_AWIDTH-1:0] OUT_ONE   = {{(OUT_AWIDTH-1){1'b0}}, 1'b1};
  localparam logic [OUT_AWIDTH-1:0] OUT_MAX   = {OUT_AWIDTH{1'b1}};

  // One-hot command state.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_SETUP = 4'b0010,
    ST_ISSUE = 4'b0100,
    ST_DRAIN = 4'b1000
  } state_t;

  // Convert stream words to AXI beats, rounding a partial beat up. The sum is
  // one bit wider so that a full-scale length cannot wrap before the shift.
  function automatic logic [CFG_DWIDTH-1:0] words_to_beats(input logic [CFG_DWIDTH-1:0] words);
    logic [CFG_DWIDTH:0] sum;
    sum = {1'b0, words} + {1'b0, ROUND_ADD};
    return CFG_DWIDTH'(sum >> CONVERT_SHIFT);
  endfunction

  // Size of the next burst: all remaining beats, capped at the AXI maximum.
  function automatic logic [CFG_DWIDTH-1:0] burst_beats(input logic [CFG_DWIDTH-1:0] beats);
    return (beats > MAX_BURST) ? MAX_BURST : beats;
  endfunction

  // awlen encoding of a burst (beats - 1).
  function automatic logic [AXI_LEN_WIDTH-1:0] burst_len(input logic [CFG_DWIDTH-1:0] burst);
    return AXI_LEN_WIDTH'(burst - CFG_ONE);
  endfunction

  // Number of bytes covered by a burst. The address wraps at 2^AXI_ADDR_WIDTH.
  function automatic logic [AXI_ADDR_WIDTH-1:0] burst_bytes(input logic [CFG_DWIDTH-1:0] burst);
    return AXI_ADDR_WIDTH'(burst) << BYTE_SHIFT;
  endfunction

  state_t                    state_q,   state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [CFG_DWIDTH-1:0]     beats_q,   beats_d;
  logic [OUT_AWIDTH-1:0]     out_q,     out_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
  logic [AXI_LEN_WIDTH-1:0]  awlen_q,   awlen_d;
  logic                      awvalid_q, awvalid_d;
  logic                      rdy_en_q,  rdy_en_d;

  logic                      idle_s;
  logic                      cmd_hs_s;
  logic                      aw_hs_s;
  logic                      b_hs_s;
  logic                      last_s;
  logic                      done_s;
  logic [CFG_DWIDTH-1:0]     burst_s;
  logic [CFG_DWIDTH-1:0]     next_burst_s;
  logic [AXI_ADDR_WIDTH-1:0] next_addr_s;
  logic [CFG_DWIDTH-1:0]     next_beats_s;

  assign idle_s   = (state_q == ST_IDLE);
  // rdy_en_q keeps cfg_rdy low in the first cycle after reset.
  assign cfg_rdy  = idle_s & data_cfg_rdy & rdy_en_q;
  assign cmd_hs_s = cfg_val & cfg_rdy;
  assign aw_hs_s  = awvalid_q & axi_awready;
  // A response with no burst in flight is ignored. This keeps the counter from underflowing.
  assign b_hs_s   = axi_bvalid & (out_q != OUT_ZERO);

  // Burst currently on AW. beats_q does not change while the burst waits, so
  // this value matches awlen_q + 1 at the handshake.
  assign burst_s      = burst_beats(beats_q);
  assign last_s       = (beats_q == burst_s);
  assign next_addr_s  = addr_q + burst_bytes(burst_s);
  assign next_beats_s = beats_q - burst_s;
  assign next_burst_s = burst_beats(next_beats_s);

  // Forward the length in the same cycle the command is accepted. An empty
  // command produces no data, so it is not forwarded.
  assign data_cfg_length = cfg_length;
  assign data_cfg_val    = cmd_hs_s & (cfg_length != CFG_ZERO);

  assign axi_awaddr  = awaddr_q;
  assign axi_awlen   = awlen_q;
  assign axi_awvalid = awvalid_q;
  assign axi_awsize  = 3'(BYTE_SHIFT);
  assign axi_awburst = 2'b01;
  assign axi_bready  = 1'b1;
  assign busy        = ~idle_s;
  assign done        = done_s;

  // Outstanding-burst count: +1 per AW handshake, -1 per accepted B. Both in the same cycle leave it unchanged.
  always_comb begin
    out_d = out_q;
    case ({aw_hs_s, b_hs_s})
      2'b10:   out_d = out_q + OUT_ONE;
      2'b01:   out_d = out_q - OUT_ONE;
      default: out_d = out_q;
    endcase
  end

  // Next-state logic, command bookkeeping and the registered AW channel.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    beats_d   = beats_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    awvalid_d = awvalid_q;
    rdy_en_d  = 1'b1;
    done_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        awvalid_d = 1'b0;
        if (cmd_hs_s) begin
          state_d = ST_SETUP;
          addr_d  = AXI_ADDR_WIDTH'(cfg_address);
          beats_d = words_to_beats(cfg_length);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (beats_q == CFG_ZERO) begin
          state_d   = ST_DRAIN;
          awvalid_d = 1'b0;
        end else begin
          // Present the first burst as this state is left, so AW starts immediately.
          state_d   = ST_ISSUE;
          awaddr_d  = addr_q;
          awlen_d   = burst_len(burst_s);
          awvalid_d = (out_d != OUT_MAX);
        end
      end
      ST_ISSUE: begin
        if (aw_hs_s) begin
          addr_d  = next_addr_s;
          beats_d = next_beats_s;
          if (last_s) begin
            state_d   = ST_DRAIN;
            awvalid_d = 1'b0;
          end else begin
            // Load the next burst at once. It is held back only while the window is full.
            state_d   = ST_ISSUE;
            awaddr_d  = next_addr_s;
            awlen_d   = burst_len(next_burst_s);
            awvalid_d = (out_d != OUT_MAX);
          end
        end else if (!awvalid_q) begin
          // The window was full. Present the pending burst once a response frees a slot.
          state_d = ST_ISSUE;
          if (out_d != OUT_MAX) begin
            awaddr_d  = addr_q;
            awlen_d   = burst_len(burst_s);
            awvalid_d = 1'b1;
          end else begin
            awvalid_d = 1'b0;
          end
        end else begin
          // Hold the stalled burst unchanged until the slave accepts it.
          state_d   = ST_ISSUE;
          awvalid_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        awvalid_d = 1'b0;
        if (out_d == OUT_ZERO) begin
          state_d = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        awvalid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= {AXI_ADDR_WIDTH{1'b0}};
      beats_q   <= CFG_ZERO;
      out_q     <= OUT_ZERO;
      awaddr_q  <= {AXI_ADDR_WIDTH{1'b0}};
      awlen_q   <= {AXI_LEN_WIDTH{1'b0}};
      awvalid_q <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      beats_q   <= beats_d;
      out_q     <= out_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      awvalid_q <= awvalid_d;
      rdy_en_q  <= rdy_en_d;
    end
  end

`ifdef AXIS_WRITE_ADDR_BRESP_EN
  logic err_q, err_d;

  // Sticky error: any response with bresp[1] set (SLVERR or DECERR).
  always_comb begin
    err_d = err_q | (axi_bvalid & axi_bresp[1]);
  end

  // Error flag register. Only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_bresp_s;
  assign unused_bresp_s = ^axi_bresp;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_axis_write_addr.sv
// Self-checking bench for axis_write_addr. It applies a table of directed
// commands, hand-written backpressure, error and reset sequences, and a
// randomized run. Every command is checked against a burst-list reference model.
module tb_axis_write_addr;

  localparam int CFG_DWIDTH     = 32;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_LEN_WIDTH  = 8;
  localparam int AXI_DATA_WIDTH = 64;
  localparam int CONVERT_SHIFT  = 1;
  localparam int OUT_AWIDTH     = 2;
  localparam int MAX_INFLIGHT   = 3;

  logic        clk;
  logic        rst;
  logic [31:0] cfg_address;
  logic [31:0] cfg_length;
  logic        cfg_val;
  logic        cfg_rdy;
  logic [31:0] data_cfg_length;
  logic        data_cfg_val;
  logic        data_cfg_rdy;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic        busy;
  logic        done;
  logic        err;

  axis_write_addr #(
    .CFG_DWIDTH(CFG_DWIDTH), .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH), .AXI_LEN_WIDTH(AXI_LEN_WIDTH),
    .AXI_DATA_WIDTH(AXI_DATA_WIDTH), .CONVERT_SHIFT(CONVERT_SHIFT), .OUT_AWIDTH(OUT_AWIDTH)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_address(cfg_address), .cfg_length(cfg_length), .cfg_val(cfg_val), .cfg_rdy(cfg_rdy),
    .data_cfg_length(data_cfg_length), .data_cfg_val(data_cfg_val), .data_cfg_rdy(data_cfg_rdy),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
    int          exp_bursts;
    logic [31:0] exp_first_addr;
    logic [7:0]  exp_first_len;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } burst_t;

  int     errors = 0;
  int     checks = 0;
  burst_t exp_q[$];
  int     n_exp, aw_cnt, b_cnt, pend_b, since_hs, stall_cnt, max_inflight;
  int     aw_hold, b_hold;
  bit     in_cmd, got_done, aw_arm, aw_rand, b_rand, err_inject, spurious_b;
  logic   exp_err;
  logic [31:0] first_addr;
  logic [7:0]  first_len;
  vec_t   vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the whole command as a list of (address, awlen) bursts.
  function automatic void build_model(input logic [31:0] a, input logic [31:0] l);
    longint unsigned beats, b;
    longint unsigned wpb = longint'(1) << CONVERT_SHIFT;
    longint unsigned maxb = longint'(1) << AXI_LEN_WIDTH;
    longint unsigned bpb = AXI_DATA_WIDTH / 8;
    logic [31:0] cur;
    exp_q.delete();
    cur   = a;
    beats = (64'(l) + wpb - 1) / wpb;
    while (beats > 0) begin
      b = (beats > maxb) ? maxb : beats;
      exp_q.push_back('{cur, 8'(b - 1)});
      cur   = cur + 32'(b * bpb);
      beats = beats - b;
    end
  endfunction

  // Called on the falling edge. It observes handshakes and checks outputs against the model.
  task automatic monitor();
    bit     b_this;
    burst_t e;
    b_this = 1'b0;
    check("err", err, exp_err);
    check("busy", busy, in_cmd && since_hs >= 1);
    if (since_hs != 0) check("data_cfg_val_quiet", data_cfg_val, 1'b0);
    if (axi_bvalid && pend_b > 0) begin
      pend_b--;
      b_cnt++;
      b_this = 1'b1;
`ifdef AXIS_WRITE_ADDR_BRESP_EN
      exp_err = exp_err | axi_bresp[1];
`endif
    end
    if (axi_awvalid) begin
      if (exp_q.size() == 0) begin
        check("aw_unexpected_valid", axi_awvalid, 1'b0);
      end else begin
        e = exp_q[0];
        check("awaddr", axi_awaddr, e.addr);
        check("awlen", axi_awlen, e.len);
        check("awsize", axi_awsize, 3'd3);
        check("awburst", axi_awburst, 2'b01);
        check("bready", axi_bready, 1'b1);
      end
      if (axi_awready) begin
        if (aw_cnt == 0) begin
          first_addr = axi_awaddr;
          first_len  = axi_awlen;
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        aw_cnt++;
        pend_b++;
        if (pend_b > max_inflight) max_inflight = pend_b;
        check("inflight_limit", pend_b <= MAX_INFLIGHT, 1'b1);
      end else begin
        stall_cnt++;
      end
      if (aw_arm) begin
        aw_arm  = 1'b0;
        aw_hold = 9;
      end
    end
    check("done", done, in_cmd && ((n_exp > 0 && b_this && b_cnt == n_exp) ||
                                   (n_exp == 0 && since_hs == 2)));
    if (in_cmd && ((n_exp > 0 && b_this && b_cnt == n_exp) || (n_exp == 0 && since_hs == 2)))
      got_done = 1'b1;
    if (since_hs >= 0) since_hs++;
  endtask

  // Called just after the rising edge. It drives the AXI slave side for the next cycle.
  task automatic drive();
    if (aw_arm) axi_awready = 1'b0;
    else if (aw_hold > 0) begin
      axi_awready = 1'b0;
      aw_hold--;
    end else axi_awready = aw_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (b_hold > 0) begin
      axi_bvalid = 1'b0;
      b_hold--;
    end else if (spurious_b) begin
      axi_bvalid = 1'b1;
      spurious_b = 1'b0;
    end else if (pend_b > 0) axi_bvalid = b_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    else axi_bvalid = 1'b0;
    if (axi_bvalid && err_inject && pend_b > 0) begin
      axi_bresp  = 2'b10;
      err_inject = 1'b0;
    end else begin
      axi_bresp = 2'b00;
    end
  endtask

  task automatic run_cmd(input vec_t v);
    bit accepted;
    build_model(v.addr, v.len);
    n_exp = exp_q.size();
    aw_cnt = 0; b_cnt = 0; pend_b = 0; since_hs = -1; stall_cnt = 0; max_inflight = 0;
    in_cmd = 1'b1; got_done = 1'b0; accepted = 1'b0;
    cfg_address = v.addr; cfg_length = v.len; cfg_val = 1'b1;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (cfg_rdy) begin
        check("data_cfg_val", data_cfg_val, v.len != 32'd0);
        check("data_cfg_length", data_cfg_length, v.len);
        since_hs = 0;
        accepted = 1'b1;
      end
      monitor();
      @(posedge clk); #1;
      drive();
    end
    cfg_val = 1'b0;
    if (!accepted) check("cfg_accept_timeout", cfg_rdy, 1'b1);
    for (int i = 0; i < 4000 && accepted && !got_done; i++) begin
      @(negedge clk);
      monitor();
      @(posedge clk); #1;
      drive();
    end
    if (!got_done) check("done_timeout", done, 1'b1);
    check("aw_count", aw_cnt, v.exp_bursts);
    check("aw_left_unissued", exp_q.size(), 0);
    if (v.exp_bursts > 0) begin
      check("first_awaddr", first_addr, v.exp_first_addr);
      check("first_awlen", first_len, v.exp_first_len);
    end
    in_cmd = 1'b0;
    @(negedge clk);
    check("busy_after_done", busy, 1'b0);
    check("done_single_pulse", done, 1'b0);
    check("cfg_rdy_after_done", cfg_rdy, 1'b1);
    check("err_sticky", err, exp_err);
    @(posedge clk); #1;
    drive();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vecs[0] = '{32'h0000_1000, 32'd16,   1, 32'h0000_1000, 8'd7};
    vecs[1] = '{32'h0000_0000, 32'd1024, 2, 32'h0000_0000, 8'd255};
    vecs[2] = '{32'h0000_2000, 32'd3,    1, 32'h0000_2000, 8'd1};
    vecs[3] = '{32'h0000_3000, 32'd0,    0, 32'h0000_0000, 8'd0};
    vecs[4] = '{32'h0000_4000, 32'd513,  2, 32'h0000_4000, 8'd255};
    vecs[5] = '{32'hFFFF_F800, 32'd1024, 2, 32'hFFFF_F800, 8'd255};

    rst = 1'b1; cfg_address = 32'd0; cfg_length = 32'd0; cfg_val = 1'b0;
    data_cfg_rdy = 1'b1; axi_awready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
    aw_hold = 0; b_hold = 0; aw_arm = 1'b0; aw_rand = 1'b0; b_rand = 1'b0;
    err_inject = 1'b0; spurious_b = 1'b0; exp_err = 1'b0; in_cmd = 1'b0;
    since_hs = -1; pend_b = 0;

    // Reset state, then cfg_rdy arming.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_cfg_rdy", cfg_rdy, 1'b0);
    check("rst_awvalid", axi_awvalid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_data_cfg_val", data_cfg_val, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("cfg_rdy_armed", cfg_rdy, 1'b1);
    @(posedge clk); #1;

    // Directed table with an always-ready slave.
    for (int i = 0; i < 6; i++) run_cmd(vecs[i]);

    // AW held off for 10 cycles. The burst must stay presented unchanged.
    aw_arm = 1'b1;
    run_cmd(vecs[0]);
    check("aw_stall_cycles", stall_cnt, 10);

    // Responses withheld: at most MAX_INFLIGHT bursts may be issued.
    b_hold = 25;
    v = '{32'h0000_8000, 32'd2048, 4, 32'h0000_8000, 8'd255};
    run_cmd(v);
    check("max_inflight", max_inflight, MAX_INFLIGHT);

    // Error response. The flag stays set through a later clean command.
    err_inject = 1'b1;
    run_cmd(vecs[0]);
    run_cmd(vecs[2]);

    // A stray response with nothing outstanding must not disturb the count.
    spurious_b = 1'b1;
    run_cmd(vecs[0]);

    // Random commands with a random ready pattern.
    aw_rand = 1'b1; b_rand = 1'b1;
    for (int i = 0; i < 12; i++) begin
      v.addr = $urandom & 32'hFFFF_FFF8;
      v.len  = 32'($urandom_range(0, 1600));
      build_model(v.addr, v.len);
      v.exp_bursts     = exp_q.size();
      v.exp_first_addr = (exp_q.size() > 0) ? exp_q[0].addr : 32'd0;
      v.exp_first_len  = (exp_q.size() > 0) ? exp_q[0].len : 8'd0;
      run_cmd(v);
    end
    aw_rand = 1'b0; b_rand = 1'b0;

    // Downstream not ready: the command must not be accepted.
    data_cfg_rdy = 1'b0; cfg_val = 1'b1; cfg_length = 32'd16; cfg_address = 32'h100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("nrdy_cfg_rdy", cfg_rdy, 1'b0);
      check("nrdy_data_cfg_val", data_cfg_val, 1'b0);
      check("nrdy_busy", busy, 1'b0);
      @(posedge clk); #1;
    end
    cfg_val = 1'b0; data_cfg_rdy = 1'b1;

    // Reset while a burst is stalled in ISSUE.
    axi_awready = 1'b0; axi_bvalid = 1'b0;
    cfg_address = 32'h0; cfg_length = 32'd1024; cfg_val = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (axi_awvalid) seen = 1'b1;
        @(posedge clk); #1;
        cfg_val = 1'b0;
      end
      check("issue_reached", seen, 1'b1);
    end
    check("issue_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_awvalid", axi_awvalid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_cfg_rdy", cfg_rdy, 1'b0);
    check("midrst_err", err, 1'b0);
    exp_err = 1'b0; pend_b = 0; exp_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_cfg_rdy_follow1", cfg_rdy, 1'b1);
    @(posedge clk); #1;
    data_cfg_rdy = 1'b0;
    @(negedge clk);
    check("midrst_cfg_rdy_follow0", cfg_rdy, 1'b0);
    @(posedge clk); #1;
    data_cfg_rdy = 1'b1;
    run_cmd(vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
